// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared direction indices, request FSM state type and helpers
//
// Purpose: common definitions for the VGA character-window control path.
//   DIR_*        : bit index of each direction in button/strobe vectors
//   req_state_e  : offset-request FSM states
//   prio_owner   : lowest set direction index (Left > Right > Up > Down)
//   dir_onehot   : one-hot strobe vector for a direction index
package vga_ctrl_pkg;

  localparam int NUM_DIRS = 4;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } req_state_e;

  // Fixed priority: the lowest set index wins. Caller guarantees req != 0.
  function automatic logic [1:0] prio_owner(input logic [NUM_DIRS-1:0] req);
    logic [1:0] idx;
    if (req[DIR_LEFT]) begin
      idx = DIR_LEFT;
    end else if (req[DIR_RIGHT]) begin
      idx = DIR_RIGHT;
    end else if (req[DIR_UP]) begin
      idx = DIR_UP;
    end else begin
      idx = DIR_DOWN;
    end
    return idx;
  endfunction

  function automatic logic [NUM_DIRS-1:0] dir_onehot(input logic [1:0] idx);
    logic [NUM_DIRS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stable-level debouncer for one button
//
// Purpose: bring one asynchronous raw button into the clk domain and only
// accept a level change after it has been stable for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk        : system clock
//   rst_ni     : asynchronous active-low reset
//   btn_raw_i  : raw active-high button, asynchronous to clk
//   btn_db_o   : debounced level, registered
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic btn_db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter tracks consecutive cycles where the synchronised level
  // disagrees with the accepted level; the change is taken on the cycle
  // that completes the run, so the counter never has to reach its top value.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/offset_request_gen.sv
// rtl/offset_request_gen.sv - one-hot offset-request strobes from four debounced push-buttons
//
// Purpose: debounce four raw buttons, give the pad to a single owner at a
// time, and emit fixed-length strobes: one on press, then auto-repeat while
// the owner stays held (first after REPEAT_DELAY, then every REPEAT_RATE).
// Ports:
//   clk        : pixel/system clock
//   reset      : asynchronous active-low reset
//   btnRaw     : raw buttons {Down, Up, Right, Left}, asynchronous to clk
//   offsetFlag : registered one-hot strobes, same bit order
//   busy       : registered, high whenever the FSM is not IDLE
module offset_request_gen
  import vga_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000,
  parameter int PULSE_LEN       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_DIRS-1:0] btnRaw,
  output logic [NUM_DIRS-1:0] offsetFlag,
  output logic                busy
);

  localparam int MAX_DR  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAX_ALL = (MAX_DR > PULSE_LEN) ? MAX_DR : PULSE_LEN;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  // Terminal values are one less than the cycle count because the cycle
  // that enters FIRE/HOLD already counts as the first cycle of that phase.
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic [NUM_DIRS-1:0] btn_db;

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk      (clk),
      .rst_ni   (reset),
      .btn_raw_i(btnRaw[g]),
      .btn_db_o (btn_db[g])
    );
  end

  req_state_e          state_q;
  req_state_e          state_d;
  logic [1:0]          owner_q;
  logic [1:0]          owner_d;
  logic                first_q;
  logic                first_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic [CW-1:0]       hold_last;
  logic [NUM_DIRS-1:0] flag_q;
  logic [NUM_DIRS-1:0] flag_d;
  logic                busy_q;
  logic                busy_d;

  // Saturating increment: the counter parks at all-ones rather than wrapping.
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign hold_last = first_q ? DELAY_LAST : RATE_LAST;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    flag_d  = '0;
    case (state_q)
      IDLE: begin
        if (|btn_db) begin
          state_d = FIRE;
          owner_d = prio_owner(btn_db);
          first_d = 1'b1;
          cnt_d   = '0;
          flag_d  = dir_onehot(owner_d);
        end
      end
      FIRE: begin
        // Release is deliberately not looked at here so the pulse is never cut short.
        if (cnt_q >= PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_inc;
          flag_d = dir_onehot(owner_q);
        end
      end
      HOLD: begin
        if (!btn_db[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= hold_last) begin
          state_d = FIRE;
          first_d = 1'b0;
          cnt_d   = '0;
          flag_d  = dir_onehot(owner_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= DIR_LEFT;
      first_q <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
    end
  end

  assign offsetFlag = flag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_offset_request_gen.sv
// tb/tb_offset_request_gen.sv - directed self-checking bench for offset_request_gen
module tb_offset_request_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int PL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btnRaw;
  logic [3:0] offsetFlag;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  offset_request_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .PULSE_LEN      (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btnRaw    (btnRaw),
    .offsetFlag(offsetFlag),
    .busy      (busy)
  );

  function automatic bit in_pulse(input int e, input int t);
    return (e >= t) && (e < t + PL);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released 1 time unit after an edge; the next edge is edge 1.
  task automatic do_reset();
    btnRaw = 4'b0000;
    reset  = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    btnRaw = 4'b0000;
    reset  = 1'b0;
    #3;
    checks++;
    if (offsetFlag !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold flag=%b busy=%b expected 0000/0", offsetFlag, busy);
    end
    step();
    step();
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (offsetFlag !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle e=%0d flag=%b busy=%b expected 0000/0", e, offsetFlag, busy);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btnRaw = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 3) btnRaw = 4'b0000;
      checks++;
      if (offsetFlag !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL glitch e=%0d flag=%b busy=%b expected 0000/0", e, offsetFlag, busy);
      end
    end
  endtask

  task automatic test_single_press();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    btnRaw = 4'b0001;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 12) btnRaw = 4'b0000;
      ef = in_pulse(e, 7) ? 4'b0001 : 4'b0000;
      eb = (e >= 7) && (e < 19);
      checks++;
      if (offsetFlag !== ef || busy !== eb) begin
        errors++;
        $display("FAIL single e=%0d flag=%b busy=%b expected %b/%b", e, offsetFlag, busy, ef, eb);
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    btnRaw = 4'b0100;
    for (int e = 1; e <= 90; e++) begin
      step();
      if (e == 60) btnRaw = 4'b0000;
      ef = (in_pulse(e, 7) || in_pulse(e, 29) || in_pulse(e, 39) ||
            in_pulse(e, 49) || in_pulse(e, 59)) ? 4'b0100 : 4'b0000;
      eb = (e >= 7) && (e < 67);
      checks++;
      if (offsetFlag !== ef || busy !== eb) begin
        errors++;
        $display("FAIL repeat e=%0d flag=%b busy=%b expected %b/%b", e, offsetFlag, busy, ef, eb);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    btnRaw = 4'b1001;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 15) btnRaw = 4'b1000;
      if (e == 30) btnRaw = 4'b0000;
      if (in_pulse(e, 7))       ef = 4'b0001;
      else if (in_pulse(e, 23)) ef = 4'b1000;
      else                      ef = 4'b0000;
      eb = ((e >= 7) && (e < 22)) || ((e >= 23) && (e < 37));
      checks++;
      if (offsetFlag !== ef || busy !== eb) begin
        errors++;
        $display("FAIL priority e=%0d flag=%b busy=%b expected %b/%b", e, offsetFlag, busy, ef, eb);
      end
    end
  endtask

  task automatic test_release_in_fire();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    btnRaw = 4'b0010;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e == 7) btnRaw = 4'b0000;
      ef = in_pulse(e, 7) ? 4'b0010 : 4'b0000;
      eb = (e >= 7) && (e < 14);
      checks++;
      if (offsetFlag !== ef || busy !== eb) begin
        errors++;
        $display("FAIL rel_fire e=%0d flag=%b busy=%b expected %b/%b", e, offsetFlag, busy, ef, eb);
      end
    end
  endtask

  task automatic test_reset_mid_fire();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    btnRaw = 4'b0010;
    for (int e = 1; e <= 7; e++) step();
    checks++;
    if (offsetFlag !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_fire_pre flag=%b busy=%b expected 0010/1", offsetFlag, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (offsetFlag !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_fire_async flag=%b busy=%b expected 0000/0", offsetFlag, busy);
    end
    step();
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      ef = in_pulse(e, 7) ? 4'b0010 : 4'b0000;
      eb = (e >= 7);
      checks++;
      if (offsetFlag !== ef || busy !== eb) begin
        errors++;
        $display("FAIL rst_fire_after e=%0d flag=%b busy=%b expected %b/%b", e, offsetFlag, busy, ef, eb);
      end
    end
    btnRaw = 4'b0000;
  endtask

  initial begin
    btnRaw = 4'b0000;
    reset  = 1'b0;
    test_reset();
    test_glitch();
    test_single_press();
    test_repeat();
    test_priority();
    test_release_in_fire();
    test_reset_mid_fire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
